// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between instruction
// fetch (IF) and load/store (MEM). One access is in flight at a time. Bus
// signals are registered and held until bus_ack or timeout. Completion is
// returned as a one-cycle ready pulse, and stall outputs freeze the pipeline
// while a side is waiting.
//
// Handshake semantics (all sides): a requester raises its request with stable
// address/data and holds it until it sees its ready pulse. Ready is high for
// exactly one cycle, and the request is still high in that cycle. The arbiter
// masks a requester whose ready is high, so the completed request is never
// granted twice. On the bus side, bus_req stays high with stable
// bus_addr/bus_we/bus_wdata until the cycle in which bus_ack is seen.
// bus_rdata is sampled in that same cycle.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_memread,
  input  logic          d_memwrite,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          err,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  // Counter only needs to reach TMO-1; the abort fires on the cycle it sits there.
  localparam int            TW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam bit            TMO_EN   = (TMO != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? TMO - 1 : 0);

  logic [1:0]    state_q, state_d;
  logic          last_d_q, last_d_d;   // 1: most recent completed grant went to data
  logic [TW-1:0] tmo_q, tmo_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q, d_ready_d;
  logic          err_q, err_d;

  logic          d_req;
  logic          if_elig, d_elig;
  logic          grant_i, grant_d;
  logic          tmo_hit, done;
  logic [DW-1:0] ret_data;

  assign d_req   = d_memread | d_memwrite;
  assign if_elig = if_req & ~if_ready_q;
  assign d_elig  = d_req & ~d_ready_q;
  // Data has priority unless it won last time; this alternates under contention.
  assign grant_d = d_elig & (~if_elig | ~last_d_q);
  assign grant_i = if_elig & ~grant_d;

  assign tmo_hit  = TMO_EN && (tmo_q == TMO_LAST) && !bus_ack;
  assign done     = bus_ack | tmo_hit;
  assign ret_data = (bus_ack && !bus_we_q) ? bus_rdata : '0;

  // Next-state logic: grant from IDLE, hold bus during BUSY, complete on ack/timeout.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    tmo_d       = tmo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d     = ST_BUSY_D;
          bus_req_d   = 1'b1;
          bus_we_d    = d_memwrite;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          tmo_d       = '0;
        end else if (grant_i) begin
          state_d     = ST_BUSY_I;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          tmo_d       = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (done) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          err_d     = ~bus_ack;
          last_d_d  = (state_q == ST_BUSY_D);
          if (state_q == ST_BUSY_D) begin
            d_rdata_d = ret_data;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = ret_data;
            if_ready_d = 1'b1;
          end
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_d_q    <= 1'b0;
      tmo_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      tmo_q       <= tmo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level model schedules
// each access arithmetically: grant cycle g, bus busy for g+1..g+L, ready at
// g+L+1, where L is the ack delay clipped to the timeout.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam int NCYC = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 0, d_memread = 0, d_memwrite = 0, bus_ack = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, bus_rdata = '0;
  logic [DW-1:0] if_rdata, d_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic          if_ready, d_ready, err, stall_if, stall_mem, bus_req, bus_we;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_memread(d_memread), .d_memwrite(d_memwrite), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / checker ----------------
  int vectors = 0;
  int miscompares = 0;
  int cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  bit          act;          // an access is scheduled/in flight
  bit          who;          // 0 fetch, 1 data
  int          g, len, rcyc, ack_cyc;
  bit          to;
  bit          a_we;
  logic [31:0] a_addr, a_wdata, rdata_exp;
  bit          last;         // 1: last completed grant was data
  bit          done_i, done_d;
  bit          rdy_i, rdy_d, in_busy;
  // requesters
  bit          if_pend, d_rd, d_wr;
  logic [31:0] if_a, d_a, d_wd;

  task automatic check_regs(input int n);
    in_busy = act && (n >= g + 1) && (n <= g + len);
    rdy_i   = act && (n == rcyc) && !who;
    rdy_d   = act && (n == rcyc) && who;
    check_eq("bus_req", bus_req, in_busy);
    if (in_busy) begin
      check_eq("bus_we", bus_we, a_we);
      check_eq("bus_addr", bus_addr, a_addr);
      if (a_we) check_eq("bus_wdata", bus_wdata, a_wdata);
    end
    check_eq("if_ready", if_ready, rdy_i);
    check_eq("d_ready", d_ready, rdy_d);
    check_eq("err", err, act && (n == rcyc) && to);
    if (rdy_i) check_eq("if_rdata", if_rdata, rdata_exp);
    if (rdy_d) check_eq("d_rdata", d_rdata, rdata_exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs(input int n);
    int p;
    int kind;
    p = (n < 60) ? 100 : 40;
    if (done_i) begin if_pend = 0; done_i = 0; end
    if (done_d) begin d_rd = 0; d_wr = 0; done_d = 0; end
    if (n == 0) begin
      if_pend = 1; if_a = 32'h0000_0040;
    end else begin
      if (!if_pend && $urandom_range(0, 99) < p) begin
        if_pend = 1; if_a = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_rd && !d_wr && $urandom_range(0, 99) < p) begin
        kind = $urandom_range(0, 3);
        d_rd = (kind <= 1) || (kind == 3);
        d_wr = (kind >= 2);
        d_a  = $urandom() & 32'hFFFF_FFFC;
        d_wd = $urandom();
      end
    end
    if_req     = if_pend;
    if_addr    = if_pend ? if_a : $urandom();
    d_memread  = d_rd;
    d_memwrite = d_wr;
    d_addr     = (d_rd || d_wr) ? d_a : $urandom();
    d_wdata    = (d_rd || d_wr) ? d_wd : $urandom();
    if (act && n == ack_cyc) begin
      bus_ack   = 1;
      bus_rdata = (n == 3) ? 32'h2008_0005 : $urandom();
      if (!a_we) rdata_exp = bus_rdata;
    end else begin
      // Stray acks outside a busy window must be ignored.
      bus_ack   = !in_busy && ($urandom_range(0, 3) == 0);
      bus_rdata = $urandom();
    end
  endtask

  task automatic model_step(input int n);
    bit ei, ed;
    int dly;
    if (act && n == rcyc) begin
      last = who;
      act  = 0;
      if (who) done_d = 1; else done_i = 1;
    end
    if (!act) begin
      ei = if_pend && !rdy_i;
      ed = (d_rd || d_wr) && !rdy_d;
      if (ei || ed) begin
        who       = (ei && ed) ? !last : ed;
        dly       = (n == 0) ? 3 : $urandom_range(1, 6);
        act       = 1;
        g         = n;
        to        = (dly > TMO);
        len       = to ? TMO : dly;
        rcyc      = g + len + 1;
        ack_cyc   = to ? -1 : g + dly;
        a_we      = who ? d_wr : 1'b0;
        a_addr    = who ? d_a : if_a;
        a_wdata   = d_wd;
        rdata_exp = '0;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int resets;
    resets = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_bus_we", bus_we, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    check_eq("rst_if_ready", if_ready, 0);
    check_eq("rst_d_ready", d_ready, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      cyc = n;
      check_regs(n);
      drive_inputs(n);
      #1;
      check_eq("stall_if", stall_if, if_pend && !rdy_i);
      check_eq("stall_mem", stall_mem, (d_rd || d_wr) && !rdy_d);
      if (n > 100 && in_busy && $urandom_range(0, 49) == 0) begin
        rst_n = 0;
        #1;
        check_eq("arst_bus_req", bus_req, 0);
        check_eq("arst_if_ready", if_ready, 0);
        check_eq("arst_d_ready", d_ready, 0);
        check_eq("arst_err", err, 0);
        resets++;
        act = 0; last = 0; done_i = 0; done_d = 0; rdy_i = 0; rdy_d = 0;
        @(negedge clk);
        rst_n = 1;
      end
      model_step(n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
